pipeline_control_sequencer: RTL and testbench

//  Multi-cycle stage sequencer plus control-signal decoder for the AVR-subset core.
//  - Latches one instruction's opcode_type/opcode_group and steps it through IF->ID->EX->MEM->WB.
//  - Tracks a per-stage cycle counter, so MEM can last several cycles (RCALL/RET), with stall and flush.
//  - Drives the one-hot pipeline_stage and the SIGNAL_COUNT control bus consumed by the register file,

---
 rtl/pipeline_control_sequencer_pkg.sv | 68 ++++++
 rtl/pipeline_control_sequencer_if.sv | 28 ++
 rtl/pipeline_control_sequencer_decoder.sv | 59 +++++
 rtl/pipeline_control_sequencer.sv | 83 ++++++++
 tb/tb_pipeline_control_sequencer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_control_sequencer_pkg.sv
// Shared indices, widths and stage encoding for the pipeline control sequencer.
package pipeline_control_sequencer_pkg;

    localparam int unsigned STAGE_COUNT  = 5;
    localparam int unsigned OPCODE_COUNT = 12;
    localparam int unsigned GROUP_COUNT  = 8;
    localparam int unsigned SIGNAL_COUNT = 9;

    // Bit positions inside pipeline_stage.
    typedef enum int unsigned {
        STAGE_IF  = 0,
        STAGE_ID  = 1,
        STAGE_EX  = 2,
        STAGE_MEM = 3,
        STAGE_WB  = 4
    } stage_idx_e;

    // Bit positions inside opcode_type (one-hot).
    typedef enum int unsigned {
        TYPE_NOP   = 0,
        TYPE_ADD   = 1,
        TYPE_SUB   = 2,
        TYPE_LDI   = 3,
        TYPE_LD    = 4,
        TYPE_ST    = 5,
        TYPE_PUSH  = 6,
        TYPE_POP   = 7,
        TYPE_RCALL = 8,
        TYPE_RET   = 9,
        TYPE_IN    = 10,
        TYPE_OUT   = 11
    } type_idx_e;

    // Bit positions inside opcode_group; one instruction may carry several.
    typedef enum int unsigned {
        GROUP_READ_RD  = 0,
        GROUP_READ_RR  = 1,
        GROUP_WRITE_RD = 2,
        GROUP_LOAD     = 3,
        GROUP_STORE    = 4,
        GROUP_IO_READ  = 5,
        GROUP_IO_WRITE = 6,
        GROUP_ALU_AUX  = 7
    } group_idx_e;

    // Bit positions inside the signals bus.
    typedef enum int unsigned {
        CONTROL_RR_READ   = 0,
        CONTROL_RD_READ   = 1,
        CONTROL_RD_WRITE  = 2,
        CONTROL_MEM_READ  = 3,
        CONTROL_MEM_WRITE = 4,
        CONTROL_IO_READ   = 5,
        CONTROL_IO_WRITE  = 6,
        CONTROL_POSTDEC   = 7,
        CONTROL_PREINC    = 8
    } control_idx_e;

    // FSM state is the one-hot stage itself, so pipeline_stage comes straight from the register.
    typedef enum logic [STAGE_COUNT-1:0] {
        StIf  = 5'b00001,
        StId  = 5'b00010,
        StEx  = 5'b00100,
        StMem = 5'b01000,
        StWb  = 5'b10000
    } stage_e;

endpackage

// File: rtl/pipeline_control_sequencer_if.sv
// Handshake bundle between the core front end (master) and the stage sequencer (slave).
interface pipeline_control_sequencer_if #(
    parameter int unsigned CYCLE_W = 2
) ();
    import pipeline_control_sequencer_pkg::*;

    logic                    instr_valid;
    logic [OPCODE_COUNT-1:0] opcode_type;
    logic [GROUP_COUNT-1:0]  opcode_group;
    logic                    stall;
    logic                    flush;
    logic [STAGE_COUNT-1:0]  pipeline_stage;
    logic [CYCLE_W-1:0]      cycle_count;
    logic [SIGNAL_COUNT-1:0] signals;
    logic                    instr_done;
    logic                    busy;

    modport master (
        output instr_valid, opcode_type, opcode_group, stall, flush,
        input  pipeline_stage, cycle_count, signals, instr_done, busy
    );

    modport slave (
        input  instr_valid, opcode_type, opcode_group, stall, flush,
        output pipeline_stage, cycle_count, signals, instr_done, busy
    );

endinterface

// File: rtl/pipeline_control_sequencer_decoder.sv
// Purely combinational decode of stage, cycle index and latched opcode into the control bus.
module pipeline_control_sequencer_decoder
    import pipeline_control_sequencer_pkg::*;
#(
    parameter int unsigned CYCLE_W        = 2,
    parameter int unsigned CALL_MEM_CYC   = 2,
    parameter int unsigned IO_EARLY_WRITE = 1
) (
    input  stage_e                  stage,
    input  logic [CYCLE_W-1:0]      cycle_count,
    input  logic [OPCODE_COUNT-1:0] opcode_type,
    input  logic [GROUP_COUNT-1:0]  opcode_group,
    output logic [SIGNAL_COUNT-1:0] signals
);

    localparam bit EarlyWrite = (IO_EARLY_WRITE != 0);

    logic in_if, in_id, in_ex, in_mem, in_wb;
    logic aux;
    logic ret_mem_preinc;

    assign in_if  = (stage == StIf);
    assign in_id  = (stage == StId);
    assign in_ex  = (stage == StEx);
    assign in_mem = (stage == StMem);
    assign in_wb  = (stage == StWb);
    assign aux    = opcode_group[GROUP_ALU_AUX];

    // RET keeps pre-incrementing SP on every MEM cycle except the last one.
    assign ret_mem_preinc = (32'(cycle_count) + 32'd1) < CALL_MEM_CYC;

    // Types that only reach the decoder through their group bits.
    logic unused_type;
    assign unused_type = ^{opcode_type[TYPE_NOP], opcode_type[TYPE_ADD], opcode_type[TYPE_SUB],
                           opcode_type[TYPE_LDI], opcode_type[TYPE_LD], opcode_type[TYPE_ST],
                           opcode_type[TYPE_IN], opcode_type[TYPE_OUT]};

    // Control bus decode; everything is zero in IF so bubbles drive nothing.
    always_comb begin
        signals = '0;
        signals[CONTROL_RR_READ]   = in_id & opcode_group[GROUP_READ_RR];
        signals[CONTROL_RD_READ]   = in_id & opcode_group[GROUP_READ_RD];
        signals[CONTROL_RD_WRITE]  = in_wb & opcode_group[GROUP_WRITE_RD];
        signals[CONTROL_MEM_READ]  = in_mem & opcode_group[GROUP_LOAD];
        signals[CONTROL_MEM_WRITE] = in_mem & opcode_group[GROUP_STORE];
        signals[CONTROL_IO_READ]   = ~in_if & opcode_group[GROUP_IO_READ];
        // Aux writes move to EX when early; never let one instruction write IO twice.
        if (EarlyWrite) begin
            signals[CONTROL_IO_WRITE] = (in_ex & aux) |
                                        (in_wb & opcode_group[GROUP_IO_WRITE] & ~aux);
        end else begin
            signals[CONTROL_IO_WRITE] = in_wb & (opcode_group[GROUP_IO_WRITE] | aux);
        end
        signals[CONTROL_POSTDEC]   = in_mem & (opcode_type[TYPE_PUSH] | opcode_type[TYPE_RCALL]);
        signals[CONTROL_PREINC]    = (in_ex & (opcode_type[TYPE_POP] | opcode_type[TYPE_RET])) |
                                     (in_mem & opcode_type[TYPE_RET] & ret_mem_preinc);
    end

endmodule

// File: rtl/pipeline_control_sequencer.sv
// Multi-cycle IF->ID->EX->MEM->WB sequencer with per-stage cycle counter, stall and flush.
module pipeline_control_sequencer
    import pipeline_control_sequencer_pkg::*;
#(
    parameter int unsigned CYCLE_W        = 2,
    parameter int unsigned CALL_MEM_CYC   = 2,
    parameter int unsigned IO_EARLY_WRITE = 1
) (
    input logic                         clk,
    input logic                         reset,
    pipeline_control_sequencer_if.slave bus
);

    localparam logic [CYCLE_W-1:0] CallLast = CYCLE_W'(CALL_MEM_CYC - 1);

    stage_e                  stage_q;
    logic [CYCLE_W-1:0]      cycle_q;
    logic [CYCLE_W-1:0]      mem_last;
    logic [OPCODE_COUNT-1:0] type_q;
    logic [GROUP_COUNT-1:0]  group_q;

    assign mem_last = (type_q[TYPE_RCALL] | type_q[TYPE_RET]) ? CallLast : '0;

    // Stage FSM, cycle counter and opcode latch; flush beats stall, both are no-ops in IF.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_q <= StIf;
            cycle_q <= '0;
            type_q  <= '0;
            group_q <= '0;
        end else if (bus.flush && (stage_q != StIf)) begin
            stage_q <= StIf;
            cycle_q <= '0;
        end else if (!bus.stall) begin
            unique case (stage_q)
                StIf: begin
                    if (bus.instr_valid) begin
                        type_q  <= bus.opcode_type;
                        group_q <= bus.opcode_group;
                        stage_q <= StId;
                    end
                end
                StId: stage_q <= StEx;
                StEx: begin
                    stage_q <= StMem;
                    cycle_q <= '0;
                end
                StMem: begin
                    if (cycle_q == mem_last) begin
                        stage_q <= StWb;
                        cycle_q <= '0;
                    end else begin
                        cycle_q <= cycle_q + 1'b1;
                    end
                end
                StWb: stage_q <= StIf;
                default: begin
                    stage_q <= StIf;
                    cycle_q <= '0;
                end
            endcase
        end
    end

    pipeline_control_sequencer_decoder #(
        .CYCLE_W        (CYCLE_W),
        .CALL_MEM_CYC   (CALL_MEM_CYC),
        .IO_EARLY_WRITE (IO_EARLY_WRITE)
    ) u_decoder (
        .stage        (stage_q),
        .cycle_count  (cycle_q),
        .opcode_type  (type_q),
        .opcode_group (group_q),
        .signals      (bus.signals)
    );

    assign bus.pipeline_stage = stage_q;
    assign bus.cycle_count    = cycle_q;
    assign bus.busy           = (stage_q != StIf);
    // Completion is only known once this cycle's stall/flush are seen, hence combinational.
    assign bus.instr_done     = (stage_q == StWb) & ~bus.stall & ~bus.flush;

endmodule

// File: tb/tb_pipeline_control_sequencer.sv
// Directed bench for pipeline_control_sequencer: two DUTs (early / late IO write) share stimulus.
module tb_pipeline_control_sequencer;
    import pipeline_control_sequencer_pkg::*;

    localparam int unsigned CW   = 2;
    localparam int          CALL = 2;

    localparam logic [11:0] T_ADD = 12'h002, T_ST = 12'h020, T_PUSH = 12'h040, T_POP = 12'h080;
    localparam logic [11:0] T_RCALL = 12'h100, T_RET = 12'h200, T_IN = 12'h400, T_OUT = 12'h800;

    logic clk, reset;
    logic s_valid, s_stall, s_flush;
    logic [11:0] s_type;
    logic [7:0]  s_group;

    pipeline_control_sequencer_if #(.CYCLE_W(CW)) bus1 ();
    pipeline_control_sequencer_if #(.CYCLE_W(CW)) bus0 ();

    assign bus1.instr_valid = s_valid;  assign bus0.instr_valid = s_valid;
    assign bus1.opcode_type = s_type;   assign bus0.opcode_type = s_type;
    assign bus1.opcode_group = s_group; assign bus0.opcode_group = s_group;
    assign bus1.stall = s_stall;        assign bus0.stall = s_stall;
    assign bus1.flush = s_flush;        assign bus0.flush = s_flush;

    pipeline_control_sequencer #(.CYCLE_W(CW), .CALL_MEM_CYC(CALL), .IO_EARLY_WRITE(1)) dut_early (
        .clk(clk), .reset(reset), .bus(bus1)
    );
    pipeline_control_sequencer #(.CYCLE_W(CW), .CALL_MEM_CYC(CALL), .IO_EARLY_WRITE(0)) dut_late (
        .clk(clk), .reset(reset), .bus(bus0)
    );

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an instruction is a queue of (stage, cycle) steps still to be visited.
    typedef struct {
        int st;
        int cy;
    } step_t;
    step_t mq[$];
    logic [11:0] m_type;
    logic [7:0]  m_group;

    function automatic logic [8:0] exp_sig(int st, int cy, logic [11:0] t, logic [7:0] g,
                                           bit early);
        logic [8:0] s;
        int wstage;
        s = '0;
        if (st == 1) begin
            s[0] = g[1];
            s[1] = g[0];
        end
        if (st == 4) s[2] = g[2];
        if (st == 3) begin
            s[3] = g[3];
            s[4] = g[4];
            s[7] = t[6] | t[8];
            s[8] = t[9] && (cy < CALL - 1);
        end
        if (st == 2) s[8] = t[7] | t[9];
        if (st != 0) s[5] = g[5];
        wstage = (early && g[7]) ? 2 : 4;
        s[6] = (g[6] | g[7]) && (st == wstage);
        return s;
    endfunction

    task automatic cmp(input string tag, input bit early, input logic [4:0] st, input logic [1:0] cy,
                       input logic [8:0] sig, input logic done, input logic busy);
        int cs, cc;
        logic [4:0] oh;
        cs = (mq.size() == 0) ? 0 : mq[0].st;
        cc = (mq.size() == 0) ? 0 : mq[0].cy;
        oh = 5'(1) << cs;
        check({tag, ".stage"}, 32'(st), 32'(oh));
        check({tag, ".cycle"}, 32'(cy), 32'(cc));
        check({tag, ".signals"}, 32'(sig), 32'(exp_sig(cs, cc, m_type, m_group, early)));
        check({tag, ".done"}, 32'(done), 32'(cs == 4 && !s_stall && !s_flush));
        check({tag, ".busy"}, 32'(busy), 32'(cs != 0));
    endtask

    // Per-cycle compare against the model, then advance the model for the coming edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                mq.delete();
                m_type  = '0;
                m_group = '0;
            end
            cmp("early", 1'b1, bus1.pipeline_stage, bus1.cycle_count, bus1.signals,
                bus1.instr_done, bus1.busy);
            cmp("late", 1'b0, bus0.pipeline_stage, bus0.cycle_count, bus0.signals,
                bus0.instr_done, bus0.busy);
            if (reset) begin
                if (mq.size() == 0) begin
                    if (!s_stall && s_valid) begin
                        m_type  = s_type;
                        m_group = s_group;
                        mq.push_back('{1, 0});
                        mq.push_back('{2, 0});
                        for (int i = 0; i < ((s_type[8] | s_type[9]) ? CALL : 1); i++)
                            mq.push_back('{3, i});
                        mq.push_back('{4, 0});
                    end
                end else if (s_flush) begin
                    mq.delete();
                end else if (!s_stall) begin
                    mq.delete(0);
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [11:0] t, input logic [7:0] g, input logic st,
                       input logic fl);
        @(posedge clk);
        #1;
        s_valid = v;
        s_type  = t;
        s_group = g;
        s_stall = st;
        s_flush = fl;
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 12'h0, 8'h0, 1'b0, 1'b0);
    endtask

    // Literal pins on both DUTs' signal buses.
    task automatic lit_sig(input string name, input logic [8:0] e1, input logic [8:0] e0);
        check({name, ".early"}, 32'(bus1.signals), 32'(e1));
        check({name, ".late"}, 32'(bus0.signals), 32'(e0));
    endtask

    // Straight-through instruction with no stall/flush, relying on the per-cycle model.
    task automatic run(input logic [11:0] t, input logic [7:0] g);
        cyc(1'b1, t, g, 1'b0, 1'b0);
        repeat (((t[8] | t[9]) ? CALL : 1) + 3) idle();
    endtask

    initial begin
        reset = 1'b1;
        s_valid = 1'b0; s_type = '0; s_group = '0; s_stall = 1'b0; s_flush = 1'b0;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst.stage", 32'(bus1.pipeline_stage), 32'h01);
        check("rst.busy", 32'(bus1.busy), 32'h0);
        lit_sig("rst.sig", 9'h000, 9'h000);
        @(posedge clk);
        #1 reset = 1'b1;

        // ADD; junk opcode (even with valid) mid-instruction must be ignored.
        cyc(1'b1, T_ADD, 8'h07, 1'b0, 1'b0);
        check("add.if", 32'(bus1.pipeline_stage), 32'h01);
        cyc(1'b0, T_ST, 8'h12, 1'b0, 1'b0);
        check("add.id", 32'(bus1.pipeline_stage), 32'h02);
        lit_sig("add.id.sig", 9'h003, 9'h003);
        cyc(1'b1, T_ST, 8'h12, 1'b0, 1'b0);
        check("add.ex", 32'(bus0.pipeline_stage), 32'h04);
        idle();
        check("add.mem", 32'(bus1.pipeline_stage), 32'h08);
        idle();
        check("add.wb", 32'(bus1.pipeline_stage), 32'h10);
        lit_sig("add.wb.sig", 9'h004, 9'h004);
        check("add.done", 32'(bus1.instr_done), 32'h1);
        idle();
        check("add.back", 32'(bus1.busy), 32'h0);

        // RET: two MEM cycles, PREINC until the last one.
        cyc(1'b1, T_RET, 8'h08, 1'b0, 1'b0);
        idle();
        idle();
        lit_sig("ret.ex", 9'h100, 9'h100);
        idle();
        lit_sig("ret.mem0", 9'h108, 9'h108);
        idle();
        lit_sig("ret.mem1", 9'h008, 9'h008);
        check("ret.mem1.cyc", 32'(bus1.cycle_count), 32'h1);
        idle();
        check("ret.wb", 32'(bus0.pipeline_stage), 32'h10);
        lit_sig("ret.wb.sig", 9'h000, 9'h000);
        idle();

        // RCALL stalled three cycles in MEM cycle 1.
        cyc(1'b1, T_RCALL, 8'h10, 1'b0, 1'b0);
        idle();
        idle();
        idle();
        lit_sig("rcall.mem0", 9'h090, 9'h090);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 12'h0, 8'h0, 1'b1, 1'b0);
            check("rcall.stall.cyc", 32'(bus1.cycle_count), 32'h1);
            lit_sig("rcall.stall.sig", 9'h090, 9'h090);
            check("rcall.stall.done", 32'(bus1.instr_done), 32'h0);
        end
        idle();
        check("rcall.held", 32'(bus1.pipeline_stage), 32'h08);
        idle();
        check("rcall.wb", 32'(bus1.pipeline_stage), 32'h10);
        idle();

        // ST flushed in EX together with stall.
        cyc(1'b1, T_ST, 8'h12, 1'b0, 1'b0);
        idle();
        cyc(1'b0, 12'h0, 8'h0, 1'b1, 1'b1);
        check("st.flush.done", 32'(bus1.instr_done), 32'h0);
        idle();
        check("st.flush.if", 32'(bus1.pipeline_stage), 32'h01);
        idle();

        // Flush in IF is ignored: PUSH still latches.
        cyc(1'b1, T_PUSH, 8'h12, 1'b0, 1'b1);
        idle();
        check("push.id", 32'(bus1.pipeline_stage), 32'h02);
        idle();
        idle();
        lit_sig("push.mem", 9'h090, 9'h090);
        idle();
        idle();

        // POP with one stalled WB cycle.
        cyc(1'b1, T_POP, 8'h0C, 1'b0, 1'b0);
        idle();
        idle();
        idle();
        cyc(1'b0, 12'h0, 8'h0, 1'b1, 1'b0);
        check("pop.wb.stall.done", 32'(bus1.instr_done), 32'h0);
        idle();
        check("pop.wb.done", 32'(bus1.instr_done), 32'h1);
        idle();

        run(T_IN, 8'h24);
        run(T_OUT, 8'h42);

        // ALU op with aux IO write: EX when early, WB when late.
        cyc(1'b1, T_ADD, 8'h87, 1'b0, 1'b0);
        idle();
        idle();
        lit_sig("aux.ex", 9'h040, 9'h000);
        idle();
        idle();
        lit_sig("aux.wb", 9'h004, 9'h044);
        idle();

        // Asynchronous reset in the middle of RET's MEM stage.
        cyc(1'b1, T_RET, 8'h08, 1'b0, 1'b0);
        idle();
        idle();
        idle();
        #1 reset = 1'b0;
        #1;
        check("arst.stage", 32'(bus1.pipeline_stage), 32'h01);
        check("arst.cyc", 32'(bus0.cycle_count), 32'h0);
        check("arst.busy", 32'(bus1.busy), 32'h0);
        lit_sig("arst.sig", 9'h000, 9'h000);
        idle();
        idle();
        reset = 1'b1;
        repeat (3) begin
            idle();
            check("arst.after", 32'(bus1.pipeline_stage), 32'h01);
            lit_sig("arst.after.sig", 9'h000, 9'h000);
        end

        @(negedge clk);
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
